// File: rtl/conv_col_sched_pkg.sv
// Shared state encoding, default sizes and width helper for the conv_col_sched slice.
// Optional build macro used elsewhere in this slice: CONV_COL_SCHED_ABORT_EN.
package conv_sched_pkg;

    localparam int BIT_WIDTH_DEF     = 8;
    localparam int NO_COL_KERNEL_DEF = 5;
    localparam int PIX_CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } sched_state_e;

    // A single-column kernel still needs a 1-bit index port.
    function automatic int kcol_w(input int n_col);
        return (n_col > 1) ? $clog2(n_col) : 1;
    endfunction

    localparam int KCOL_W_DEF = kcol_w(NO_COL_KERNEL_DEF);

endpackage

// File: rtl/conv_col_sched_if.sv
// Bus bundle between conv_col_sched and its weight buffer, pixel source and multi_mul.
// Optional build macro affecting the scheduler (not this bundle): CONV_COL_SCHED_ABORT_EN.
interface conv_col_sched_if #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5
);

    localparam int KCOL_W = conv_sched_pkg::kcol_w(NO_COL_KERNEL);
    localparam int WCOL_W = BIT_WIDTH * NO_COL_KERNEL;

    // Handshakes: weight fetch completes on the edge where o_wgt_req and i_wgt_vld are both
    // high (request and address held until then); a pixel transfers on the edge where
    // i_pix_vld and o_pix_rdy are both high, and o_pix_rdy follows i_mm_ready combinationally.
    logic              o_wgt_req;
    logic [KCOL_W-1:0] o_wgt_addr;
    logic              i_wgt_vld;
    logic [WCOL_W-1:0] i_wgt_data;

    logic                 i_pix_vld;
    logic [BIT_WIDTH-1:0] i_pix_data;
    logic                 o_pix_rdy;

    logic                 i_mm_ready;
    logic [WCOL_W-1:0]    o_weight_col;
    logic [BIT_WIDTH-1:0] o_pix_feature_map;
    logic                 o_enable_colw;
    logic                 o_enable_colip;

    modport master (
        output o_wgt_req, o_wgt_addr,
        input  i_wgt_vld, i_wgt_data,
        input  i_pix_vld, i_pix_data,
        output o_pix_rdy,
        input  i_mm_ready,
        output o_weight_col, o_pix_feature_map, o_enable_colw, o_enable_colip
    );

    modport slave (
        input  o_wgt_req, o_wgt_addr,
        output i_wgt_vld, i_wgt_data,
        output i_pix_vld, i_pix_data,
        input  o_pix_rdy,
        output i_mm_ready,
        input  o_weight_col, o_pix_feature_map, o_enable_colw, o_enable_colip
    );

endinterface

// File: rtl/conv_col_sched_counter.sv
// Kernel-column index plus per-column pixel counter, with end-of-column and last-column flags.
// Optional build macro used by the parent scheduler: CONV_COL_SCHED_ABORT_EN.
module col_pix_counter #(
    parameter int KCOL_W        = 3,
    parameter int PIX_CNT_W     = 8,
    parameter int NO_COL_KERNEL = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_col_clr,
    input  logic                 i_col_inc,
    input  logic                 i_pix_clr,
    input  logic                 i_pix_inc,
    input  logic [PIX_CNT_W-1:0] i_npix,
    output logic [KCOL_W-1:0]    o_kcol,
    output logic                 o_col_end,
    output logic                 o_last_col
);

    localparam logic [PIX_CNT_W-1:0] PIX_ONE  = PIX_CNT_W'(1);
    localparam logic [KCOL_W-1:0]    KCOL_ONE = KCOL_W'(1);
    localparam logic [KCOL_W-1:0]    KCOL_MAX = KCOL_W'(NO_COL_KERNEL - 1);

    logic [PIX_CNT_W-1:0] pix_cnt_q;
    logic [KCOL_W-1:0]    kcol_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            kcol_q    <= '0;
            pix_cnt_q <= '0;
        end else begin
            if (i_col_clr) begin
                kcol_q <= '0;
            end else if (i_col_inc) begin
                kcol_q <= kcol_q + KCOL_ONE;
            end
            if (i_pix_clr) begin
                pix_cnt_q <= '0;
            end else if (i_pix_inc) begin
                pix_cnt_q <= pix_cnt_q + PIX_ONE;
            end
        end
    end

    // Compare against npix-1 so the maximum npix never needs a wider counter.
    assign o_col_end  = (pix_cnt_q == (i_npix - PIX_ONE));
    assign o_last_col = (kcol_q == KCOL_MAX);
    assign o_kcol     = kcol_q;

endmodule

// File: rtl/conv_col_sched.sv
// Per-job sequencer: fetches each kernel column's weights into multi_mul, then streams npix pixels.
// Optional build macro CONV_COL_SCHED_ABORT_EN adds an i_abort input that returns to idle.
module conv_col_sched
    import conv_sched_pkg::*;
#(
    parameter int BIT_WIDTH     = BIT_WIDTH_DEF,
    parameter int NO_COL_KERNEL = NO_COL_KERNEL_DEF,
    parameter int PIX_CNT_W     = PIX_CNT_W_DEF
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [PIX_CNT_W-1:0]              i_cfg_npix,
`ifdef CONV_COL_SCHED_ABORT_EN
    input  logic                              i_abort,
`endif
    output logic                              o_busy,
    output logic                              o_done,
    output logic [kcol_w(NO_COL_KERNEL)-1:0]  o_kercol_idx,
    output logic [1:0]                        o_dbg_state,
    conv_col_sched_if.master                  bus
);

    localparam int KCOL_W = kcol_w(NO_COL_KERNEL);
    localparam int WCOL_W = BIT_WIDTH * NO_COL_KERNEL;

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_LOAD_W = 2'(LOAD_W);
    localparam logic [1:0] S_STREAM = 2'(STREAM);
    localparam logic [1:0] S_DONE   = 2'(DONE);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [PIX_CNT_W-1:0] npix_q;
    logic [WCOL_W-1:0]    weight_col_q;
    logic [BIT_WIDTH-1:0] pix_q;
    logic                 en_colw_q;
    logic                 en_colip_q;

    logic              abort_w;
    logic              start_acc;
    logic              wgt_take;
    logic              pix_rdy;
    logic              fire;
    logic              col_end;
    logic              last_col;
    logic              col_inc;
    logic [KCOL_W-1:0] kcol;

`ifdef CONV_COL_SCHED_ABORT_EN
    assign abort_w = i_abort & (state_q != S_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    // An aborting cycle neither completes a fetch nor accepts a pixel.
    assign start_acc = (state_q == S_IDLE) & i_start;
    assign wgt_take  = (state_q == S_LOAD_W) & bus.i_wgt_vld & ~abort_w;
    assign pix_rdy   = (state_q == S_STREAM) & bus.i_mm_ready & ~abort_w;
    assign fire      = pix_rdy & bus.i_pix_vld;
    assign col_inc   = fire & col_end & ~last_col;

    col_pix_counter #(
        .KCOL_W        (KCOL_W),
        .PIX_CNT_W     (PIX_CNT_W),
        .NO_COL_KERNEL (NO_COL_KERNEL)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_col_clr  (start_acc),
        .i_col_inc  (col_inc),
        .i_pix_clr  (wgt_take | start_acc),
        .i_pix_inc  (fire),
        .i_npix     (npix_q),
        .o_kcol     (kcol),
        .o_col_end  (col_end),
        .o_last_col (last_col)
    );

    always_comb begin
        state_d = state_q;
        if (abort_w) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = (i_cfg_npix != '0) ? S_LOAD_W : S_DONE;
                    end
                end
                S_LOAD_W: begin
                    if (wgt_take) begin
                        state_d = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (fire && col_end) begin
                        state_d = last_col ? S_DONE : S_LOAD_W;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            npix_q       <= '0;
            weight_col_q <= '0;
            pix_q        <= '0;
            en_colw_q    <= 1'b0;
            en_colip_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_colw_q  <= wgt_take;
            en_colip_q <= fire;
            if (start_acc) begin
                npix_q <= i_cfg_npix;
            end
            if (wgt_take) begin
                weight_col_q <= bus.i_wgt_data;
            end
            if (fire) begin
                pix_q <= bus.i_pix_data;
            end
        end
    end

    assign bus.o_wgt_req         = (state_q == S_LOAD_W);
    assign bus.o_wgt_addr        = kcol;
    assign bus.o_pix_rdy         = pix_rdy;
    assign bus.o_weight_col      = weight_col_q;
    assign bus.o_pix_feature_map = pix_q;
    assign bus.o_enable_colw     = en_colw_q;
    assign bus.o_enable_colip    = en_colip_q;

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_kercol_idx = kcol;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_conv_col_sched.sv
// Randomized bench for conv_col_sched against a job-level reference model with a pixel scoreboard.
// Build with CONV_COL_SCHED_ABORT_EN defined to also exercise i_abort.
module tb_conv_col_sched;

  localparam int BW = 8;
  localparam int NK = 5;
  localparam int PW = 8;
  localparam int KW = 3;
  localparam int WW = BW * NK;

  localparam int P_IDLE   = 0;
  localparam int P_FETCH  = 1;
  localparam int P_STREAM = 2;
  localparam int P_DONE   = 3;

  // clock / reset
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [PW-1:0] i_cfg_npix = '0;
  logic i_abort = 1'b0;
  logic o_busy;
  logic o_done;
  logic [KW-1:0] o_kercol_idx;
  logic [1:0] o_dbg_state;

  always #5 i_clk = ~i_clk;

  conv_col_sched_if #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK)) bus ();

  conv_col_sched #(.BIT_WIDTH(BW), .NO_COL_KERNEL(NK), .PIX_CNT_W(PW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_cfg_npix   (i_cfg_npix),
`ifdef CONV_COL_SCHED_ABORT_EN
    .i_abort      (i_abort),
`endif
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_kercol_idx (o_kercol_idx),
    .o_dbg_state  (o_dbg_state),
    .bus          (bus)
  );

  // stimulus controls
  logic rst_drive = 1'b0;
  logic abort_drive = 1'b0;
  logic start_pend = 1'b0;
  logic [PW-1:0] cfg_val = '0;
  int rmode = 0;
  int vprob = 100;
  int lat_fixed = 1;
  logic stall_data = 1'b0;
  logic poke = 1'b0;
  logic tog = 1'b0;

  // reference model: job phase, column, pixels left, and expected output values
  int m_phase = P_IDLE;
  int m_col = 0;
  int m_npix = 0;
  int m_left = 0;
  int m_wait = 0;
  int m_lat = 0;
  logic [WW-1:0] m_wcol = '0;
  logic [BW-1:0] m_pix = '0;
  logic m_colw_pend = 1'b0;
  logic m_colip_pend = 1'b0;

  // scoreboard
  logic [BW-1:0] exp_q[$];
  int done_seen = 0;
  int colip_seen = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    return (lat_fixed < 0) ? int'($urandom_range(0, 4)) : lat_fixed;
  endfunction

  // driver: one clock cycle of stimulus, checks, then model advance
  task automatic step();
    logic fire;
    logic mm;
    logic [BW-1:0] pexp;
    @(negedge i_clk);
    i_rst_n = rst_drive;
    i_abort = abort_drive;
    if (m_phase == P_IDLE) begin
      i_start    = start_pend;
      i_cfg_npix = cfg_val;
    end else begin
      i_start    = poke && ($urandom_range(0, 3) == 0);
      i_cfg_npix = PW'($urandom);
    end
    tog = ~tog;
    case (rmode)
      0:       mm = 1'b1;
      1:       mm = tog;
      default: mm = 1'($urandom_range(0, 1));
    endcase
    bus.i_mm_ready = mm;
    bus.i_pix_vld  = ($urandom_range(0, 99) < vprob);
    bus.i_pix_data = BW'($urandom);
    bus.i_wgt_data = stall_data ? WW'(40'hA1B2C3D4E5) : WW'({$urandom, $urandom});
    if (m_phase == P_FETCH) bus.i_wgt_vld = (m_wait >= m_lat);
    else bus.i_wgt_vld = ($urandom_range(0, 3) == 0);
    #1;
    check_eq("busy", o_busy, m_phase != P_IDLE);
    check_eq("done", o_done, m_phase == P_DONE);
    check_eq("wgt_req", bus.o_wgt_req, m_phase == P_FETCH);
    if (m_phase == P_FETCH) check_eq("wgt_addr", bus.o_wgt_addr, m_col);
    check_eq("kercol_idx", o_kercol_idx, m_col);
    check_eq("pix_rdy", bus.o_pix_rdy, (m_phase == P_STREAM) && bus.i_mm_ready && !i_abort);
    check_eq("enable_colw", bus.o_enable_colw, m_colw_pend);
    check_eq("enable_colip", bus.o_enable_colip, m_colip_pend);
    check_eq("weight_col", bus.o_weight_col, m_wcol);
    check_eq("pix_fm", bus.o_pix_feature_map, m_pix);
    if (bus.o_enable_colip) begin
      colip_seen++;
      if (exp_q.size() == 0) check_eq("sb_underflow", bus.o_enable_colip, 1'b0);
      else begin
        pexp = exp_q.pop_front();
        check_eq("sb_pixel", bus.o_pix_feature_map, pexp);
      end
    end
    if (o_done) done_seen++;

    fire = (m_phase == P_STREAM) && bus.i_mm_ready && bus.i_pix_vld && !i_abort;
    m_colw_pend  = 1'b0;
    m_colip_pend = 1'b0;
    if (!i_rst_n) begin
      m_phase = P_IDLE; m_col = 0; m_npix = 0; m_left = 0;
      m_wcol = '0; m_pix = '0;
      exp_q.delete();
    end else if (i_abort && m_phase != P_IDLE) begin
      m_phase = P_IDLE;
    end else begin
      m_colip_pend = fire;
      case (m_phase)
        P_IDLE: if (i_start) begin
          start_pend = 1'b0;
          m_npix = int'(i_cfg_npix);
          m_col  = 0;
          m_wait = 0;
          m_lat  = pick_lat();
          m_phase = (m_npix == 0) ? P_DONE : P_FETCH;
        end
        P_FETCH: if (bus.i_wgt_vld) begin
          m_wcol = bus.i_wgt_data;
          m_colw_pend = 1'b1;
          m_left = m_npix;
          m_phase = P_STREAM;
        end else m_wait++;
        P_STREAM: if (fire) begin
          m_pix = bus.i_pix_data;
          exp_q.push_back(bus.i_pix_data);
          m_left--;
          if (m_left == 0) begin
            if (m_col == NK - 1) m_phase = P_DONE;
            else begin
              m_col++;
              m_wait = 0;
              m_lat = pick_lat();
              m_phase = P_FETCH;
            end
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic run_job(input int npix, input int rm, input int vp, input int lat,
                         input logic stall, input logic pk);
    int cyc;
    cfg_val = PW'(npix); rmode = rm; vprob = vp; lat_fixed = lat;
    stall_data = stall; poke = pk;
    done_seen = 0; colip_seen = 0; start_pend = 1'b1; cyc = 0;
    do begin
      step();
      cyc++;
    end while ((start_pend || m_phase != P_IDLE) && cyc < 20000);
    check_eq("job_cycle_budget", cyc < 20000, 1'b1);
    check_eq("job_done_count", done_seen, 1);
    check_eq("job_pixel_count", colip_seen, npix * NK);
  endtask

  task automatic run_reset_mid();
    int cyc;
    cfg_val = 4; rmode = 2; vprob = 70; lat_fixed = -1; stall_data = 1'b0; poke = 1'b0;
    done_seen = 0; colip_seen = 0; start_pend = 1'b1; cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(m_phase == P_STREAM && m_col == 2) && cyc < 5000);
    check_eq("rst_reach_col2", cyc < 5000, 1'b1);
    rst_drive = 1'b0;
    step();
    rst_drive = 1'b1;
    step();
    check_eq("rst_mid_busy", o_busy, 1'b0);
    check_eq("rst_mid_kcol", o_kercol_idx, 0);
    check_eq("rst_mid_weight_col", bus.o_weight_col, 0);
    check_eq("rst_mid_pix_fm", bus.o_pix_feature_map, 0);
    check_eq("rst_mid_no_done", done_seen, 0);
  endtask

  initial begin
    bus.i_wgt_vld = 1'b0;
    bus.i_wgt_data = '0;
    bus.i_pix_vld = 1'b0;
    bus.i_pix_data = '0;
    bus.i_mm_ready = 1'b0;
    repeat (3) step();
    check_eq("reset_busy", o_busy, 1'b0);
    check_eq("reset_done", o_done, 1'b0);
    check_eq("reset_req", bus.o_wgt_req, 1'b0);
    check_eq("reset_kcol", o_kercol_idx, 0);
    check_eq("reset_colip", bus.o_enable_colip, 1'b0);
    rst_drive = 1'b1;
    step();

    run_job(3, 0, 100, 1, 1'b0, 1'b0);
    run_job(3, 1, 100, 0, 1'b0, 1'b0);
    run_job(2, 0, 100, 4, 1'b1, 1'b0);
    check_eq("stall_weight_col", bus.o_weight_col, WW'(40'hA1B2C3D4E5));
    run_job(0, 0, 100, 1, 1'b0, 1'b1);
    run_job(255, 2, 80, -1, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(1, 12)), int'($urandom_range(0, 2)),
              int'($urandom_range(30, 100)), -1, 1'b0, 1'b1);
    end
    run_reset_mid();
    run_job(2, 2, 90, -1, 1'b0, 1'b1);

`ifdef CONV_COL_SCHED_ABORT_EN
    begin
      int cyc;
      cfg_val = 3; rmode = 0; vprob = 100; lat_fixed = 4; stall_data = 1'b0; poke = 1'b0;
      done_seen = 0; start_pend = 1'b1; cyc = 0;
      do begin
        step();
        cyc++;
      end while (m_phase != P_FETCH && cyc < 100);
      abort_drive = 1'b1;
      step();
      abort_drive = 1'b0;
      step();
      check_eq("abort_busy", o_busy, 1'b0);
      check_eq("abort_req", bus.o_wgt_req, 1'b0);
      check_eq("abort_no_done", done_seen, 0);
      run_job(1, 0, 100, 0, 1'b0, 1'b0);
    end
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
